// File: rtl/tx_huge_pages_rd_req_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_huge_pages_rd_req_if
// Brief    : TRN transmit bus bundle between the read-request engine and core.
// Revision : 1.0 - initial release
// ============================================================================
interface tx_huge_pages_rd_req_if;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n;

  modport master (
    output trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
    input  trn_tdst_rdy_n
  );

  modport slave (
    input  trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
    output trn_tdst_rdy_n
  );
endinterface
`default_nettype wire

// File: rtl/tx_huge_pages_rd_req.sv
`default_nettype none
// ============================================================================
// Module   : tx_huge_pages_rd_req
// Brief    : Fetches unlocked huge pages alternately as chunked MRd TLPs and
//            pulses the page free flag once all completion qwords returned.
//            Define TX_RD32_EN to emit 3DW MRd32 for addresses below 4 GB.
// Revision : 1.0 - initial release
// ============================================================================
module tx_huge_pages_rd_req #(
  parameter int MAX_RD_QW  = 64,
  parameter int MAX_OUT_QW = 256
) (
  input  wire                     trn_clk,
  input  wire                     reset_n,
  tx_huge_pages_rd_req_if.master  trn,
  input  wire  [15:0]             cfg_completer_id,
  input  wire  [63:0]             huge_page_addr_1,
  input  wire  [63:0]             huge_page_addr_2,
  input  wire  [31:0]             huge_page_qwords_1,
  input  wire  [31:0]             huge_page_qwords_2,
  input  wire                     huge_page_status_1,
  input  wire                     huge_page_status_2,
  output logic                    huge_page_free_1,
  output logic                    huge_page_free_2,
  input  wire                     cpl_qw_valid
);

  localparam logic [31:0] c_MAX_RD_QW  = 32'(MAX_RD_QW);
  localparam logic [32:0] c_MAX_OUT_QW = 33'(MAX_OUT_QW);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GATE = 3'd1,
    S_HDR0 = 3'd2,
    S_HDR1 = 3'd3,
    S_WAIT = 3'd4,
    S_FREE = 3'd5
  } state_t;

  state_t      state_q;
  logic        cur_q;          // 0 = page 1, 1 = page 2
  logic [4:0]  tag_q;
  logic [63:0] addr_q;
  logic [31:0] total_q;
  logic [31:0] req_q;
  logic [31:0] rcv_q;
  logic [31:0] chunk_q;
  logic [1:0]  free_q;
  logic [63:0] td_q;
  logic [7:0]  trem_q;
  logic        sof_q;
  logic        eof_q;
  logic        src_q;

  logic        w_page_rdy;
  logic [63:0] w_page_addr;
  logic [31:0] w_page_qw;
  logic [31:0] w_remain;
  logic [31:0] w_chunk;
  logic [32:0] w_outst;
  logic [9:0]  w_len;
  logic        w_rd32;
  logic [6:0]  w_fmt;
  logic [63:0] w_beat0;
  logic [63:0] w_beat1;
  logic [7:0]  w_trem1;

`ifdef TX_RD32_EN
  assign w_rd32 = (addr_q[63:32] == 32'd0);
`else
  assign w_rd32 = 1'b0;
`endif

  always_comb begin
    w_page_rdy  = cur_q ? huge_page_status_2 : huge_page_status_1;
    w_page_addr = cur_q ? huge_page_addr_2   : huge_page_addr_1;
    w_page_qw   = cur_q ? huge_page_qwords_2 : huge_page_qwords_1;
    w_remain    = total_q - req_q;
    w_chunk     = (w_remain > c_MAX_RD_QW) ? c_MAX_RD_QW : w_remain;
    // Outstanding window includes the chunk about to be requested.
    w_outst     = {1'b0, req_q - rcv_q} + {1'b0, w_chunk};
    w_len       = {w_chunk[8:0], 1'b0};
    w_fmt       = w_rd32 ? 7'b00_00000 : 7'b01_00000;
    w_beat0     = {1'b0, w_fmt, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00,
                   w_len, cfg_completer_id, 3'b000, tag_q, 4'hF, 4'hF};
    w_beat1     = w_rd32 ? {addr_q[31:0] & 32'hFFFF_FFF8, 32'h0000_0000}
                         : (addr_q & 64'hFFFF_FFFF_FFFF_FFF8);
    w_trem1     = w_rd32 ? 8'h0F : 8'h00;
  end

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cur_q   <= 1'b0;
      tag_q   <= 5'd0;
      addr_q  <= 64'd0;
      total_q <= 32'd0;
      req_q   <= 32'd0;
      rcv_q   <= 32'd0;
      chunk_q <= 32'd0;
      free_q  <= 2'b00;
      td_q    <= 64'd0;
      trem_q  <= 8'hFF;
      sof_q   <= 1'b1;
      eof_q   <= 1'b1;
      src_q   <= 1'b1;
    end else begin
      free_q <= 2'b00;
      if (cpl_qw_valid && (state_q != S_IDLE) && (state_q != S_FREE)) begin
        rcv_q <= rcv_q + 32'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (w_page_rdy) begin
            addr_q  <= w_page_addr;
            total_q <= w_page_qw;
            req_q   <= 32'd0;
            rcv_q   <= 32'd0;
            if (w_page_qw == 32'd0) begin
              free_q  <= cur_q ? 2'b10 : 2'b01;
              state_q <= S_FREE;
            end else begin
              state_q <= S_GATE;
            end
          end
        end
        S_GATE: begin
          if (w_outst <= c_MAX_OUT_QW) begin
            chunk_q <= w_chunk;
            td_q    <= w_beat0;
            trem_q  <= 8'h00;
            sof_q   <= 1'b0;
            src_q   <= 1'b0;
            state_q <= S_HDR0;
          end
        end
        S_HDR0: begin
          if (!trn.trn_tdst_rdy_n) begin
            td_q    <= w_beat1;
            trem_q  <= w_trem1;
            sof_q   <= 1'b1;
            eof_q   <= 1'b0;
            state_q <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (!trn.trn_tdst_rdy_n) begin
            td_q    <= 64'd0;
            trem_q  <= 8'hFF;
            eof_q   <= 1'b1;
            src_q   <= 1'b1;
            addr_q  <= addr_q + (64'(chunk_q) << 3);
            req_q   <= req_q + chunk_q;
            tag_q   <= tag_q + 5'd1;
            state_q <= ((req_q + chunk_q) == total_q) ? S_WAIT : S_GATE;
          end
        end
        S_WAIT: begin
          if (rcv_q == total_q) begin
            free_q  <= cur_q ? 2'b10 : 2'b01;
            state_q <= S_FREE;
          end
        end
        S_FREE: begin
          cur_q   <= ~cur_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign trn.trn_td         = td_q;
  assign trn.trn_trem_n     = trem_q;
  assign trn.trn_tsof_n     = sof_q;
  assign trn.trn_teof_n     = eof_q;
  assign trn.trn_tsrc_rdy_n = src_q;
  assign huge_page_free_1   = free_q[0];
  assign huge_page_free_2   = free_q[1];

endmodule
`default_nettype wire

// File: tb/tb_tx_huge_pages_rd_req.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_huge_pages_rd_req
// Brief    : Directed bench with a TLP/page-level reference model and monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_huge_pages_rd_req;
  localparam int MAX_RD_QW  = 64;
  localparam int MAX_OUT_QW = 128;

  logic        trn_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cid = 16'h0;
  logic [63:0] a1 = 64'h0, a2 = 64'h0;
  logic [31:0] q1 = 32'h0, q2 = 32'h0;
  logic        s1 = 1'b0, s2 = 1'b0;
  logic        f1, f2;
  logic        cpl = 1'b0;

  always #5 trn_clk = ~trn_clk;

  tx_huge_pages_rd_req_if trn_if();

  tx_huge_pages_rd_req #(.MAX_RD_QW(MAX_RD_QW), .MAX_OUT_QW(MAX_OUT_QW)) dut (
    .trn_clk(trn_clk), .reset_n(reset_n), .trn(trn_if),
    .cfg_completer_id(cid),
    .huge_page_addr_1(a1), .huge_page_addr_2(a2),
    .huge_page_qwords_1(q1), .huge_page_qwords_2(q2),
    .huge_page_status_1(s1), .huge_page_status_2(s2),
    .huge_page_free_1(f1), .huge_page_free_2(f2),
    .cpl_qw_valid(cpl)
  );

  typedef struct {
    logic [63:0] b0;
    logic [63:0] b1;
    logic [7:0]  trem1;
    int          chunk;
    int          pidx;
  } tlp_t;

  tlp_t        exp_q[$];
  int          free_q[$];
  int          tot_q[$];
  logic [63:0] cap_b0[$];
  logic [63:0] cap_b1[$];
  logic [4:0]  m_tag = 5'd0;
  int m_req = 0, m_rcv = 0, m_rcv_page = 0, freed = 0, pushed = 0, n_tlp = 0;
  int cpl_budget = 0;
  int n_tests = 0, n_fail = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Expected TLP stream of one page, derived from chunking rules.
  task automatic push_page(int page, logic [63:0] addr, int qw);
    tlp_t t;
    int done = 0;
    int c;
    logic rd32;
    logic [63:0] a = addr;
    while (done < qw) begin
      c = (qw - done > MAX_RD_QW) ? MAX_RD_QW : qw - done;
`ifdef TX_RD32_EN
      rd32 = (a[63:32] == 32'd0);
`else
      rd32 = 1'b0;
`endif
      t.b0 = {1'b0, (rd32 ? 7'h00 : 7'h20), 1'b0, 3'b0, 4'b0, 1'b0, 1'b0, 2'b0, 2'b0,
              10'(c * 2), cid, 3'b0, m_tag, 8'hFF};
      t.b1    = rd32 ? {a[31:0], 32'h0} : a;
      t.trem1 = rd32 ? 8'h0F : 8'h00;
      t.chunk = c;
      t.pidx  = pushed;
      exp_q.push_back(t);
      m_tag = m_tag + 5'd1;
      a     = a + 64'(c * 8);
      done  = done + c;
    end
    free_q.push_back(page);
    tot_q.push_back(qw);
    pushed++;
  endtask

  // Monitor / compare process.
  logic        prev_stall = 1'b0, prev_free = 1'b0, in_frame = 1'b0;
  logic [74:0] prev_bus;
  always @(negedge trn_clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0; prev_free = 1'b0; in_frame = 1'b0;
    end else begin
      if (cpl) begin m_rcv++; m_rcv_page++; end
      if (prev_stall)
        check("beat_hold", {trn_if.trn_tsrc_rdy_n, trn_if.trn_tsof_n, trn_if.trn_teof_n,
                            trn_if.trn_trem_n, trn_if.trn_td}, prev_bus);
      if (!trn_if.trn_tsrc_rdy_n && !trn_if.trn_tdst_rdy_n) begin
        if (!trn_if.trn_tsof_n) begin
          if (exp_q.size() == 0 || in_frame) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_sof: td=%0h expected no new frame", trn_if.trn_td);
          end else begin
            check("beat0", trn_if.trn_td, exp_q[0].b0);
            check("beat0_eof", trn_if.trn_teof_n, 1'b1);
            check("page_order", freed, exp_q[0].pidx);
            check("outstanding_limit", (m_req - m_rcv + exp_q[0].chunk) <= MAX_OUT_QW, 1'b1);
            cap_b0.push_back(trn_if.trn_td);
            in_frame = 1'b1;
          end
        end else if (!trn_if.trn_teof_n) begin
          if (!in_frame || exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_eof: td=%0h expected no beat", trn_if.trn_td);
          end else begin
            check("beat1", trn_if.trn_td, exp_q[0].b1);
            check("beat1_trem", trn_if.trn_trem_n, exp_q[0].trem1);
            m_req += exp_q[0].chunk;
            cap_b1.push_back(trn_if.trn_td);
            void'(exp_q.pop_front());
            n_tlp++;
            in_frame = 1'b0;
          end
        end else begin
          n_tests++; n_fail++;
          $display("FAIL stray_beat: sof_n=1 eof_n=1 required one of them low");
        end
      end
      prev_stall = !trn_if.trn_tsrc_rdy_n && trn_if.trn_tdst_rdy_n;
      prev_bus   = {trn_if.trn_tsrc_rdy_n, trn_if.trn_tsof_n, trn_if.trn_teof_n,
                    trn_if.trn_trem_n, trn_if.trn_td};
      if (prev_free) check("free_pulse_len", f1 | f2, 1'b0);
      if ((f1 || f2) && !prev_free) begin
        check("free_onehot", f1 & f2, 1'b0);
        if (free_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_free: f1=%0b f2=%0b expected none", f1, f2);
        end else begin
          check("free_page", f1 ? 1 : 2, free_q[0]);
          check("free_all_rcv", m_rcv_page, tot_q[0]);
          check("free_all_req", exp_q.size() == 0 || exp_q[0].pidx != freed, 1'b1);
          void'(free_q.pop_front());
          void'(tot_q.pop_front());
          freed++;
          m_rcv_page = 0;
        end
      end
      prev_free = f1 | f2;
    end
  end

  // Completion responder: returns qwords the model knows are outstanding.
  always @(posedge trn_clk) begin
    #2;
    if (reset_n && cpl_budget > 0 && (m_req - m_rcv) > 0) begin
      cpl = 1'b1;
      cpl_budget--;
    end else begin
      cpl = 1'b0;
    end
  end

  task automatic do_reset();
    reset_n = 1'b0; s1 = 1'b0; s2 = 1'b0; cpl_budget = 0;
    trn_if.trn_tdst_rdy_n = 1'b0;
    repeat (3) @(posedge trn_clk);
    #1;
    exp_q.delete(); free_q.delete(); tot_q.delete(); cap_b0.delete(); cap_b1.delete();
    m_tag = 5'd0; m_req = 0; m_rcv = 0; m_rcv_page = 0; freed = 0; pushed = 0; n_tlp = 0;
    check("reset_ctl", {trn_if.trn_tsof_n, trn_if.trn_teof_n, trn_if.trn_tsrc_rdy_n}, 3'b111);
    check("reset_td", trn_if.trn_td, 64'h0);
    check("reset_trem", trn_if.trn_trem_n, 8'hFF);
    check("reset_free", {f1, f2}, 2'b00);
    reset_n = 1'b1;
  endtask

  task automatic wait_freed(int target, int budget, string name);
    int k = 0;
    while (freed < target && k < budget) begin
      @(negedge trn_clk); #1;
      k++;
    end
    n_tests++;
    if (freed < target) begin
      n_fail++;
      $display("FAIL %s: timeout freed=%0d required=%0d", name, freed, target);
    end
    @(posedge trn_clk); #1;
  endtask

  task automatic wait_src(int budget, string name);
    int k = 0;
    while (trn_if.trn_tsrc_rdy_n && k < budget) begin
      @(posedge trn_clk); #1;
      k++;
    end
    check(name, trn_if.trn_tsrc_rdy_n, 1'b0);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge trn_clk);
    #1;
  endtask

  int          exp_len[4]  = '{128, 128, 128, 16};
  logic [63:0] exp_off[4]  = '{64'd0, 64'd512, 64'd1024, 64'd1536};

  initial begin
    trn_if.trn_tdst_rdy_n = 1'b0;
    @(posedge trn_clk); #1;

    // Single 64-qword page above 4 GB.
    do_reset();
    cid = 16'h0100; a1 = 64'h0000_0001_0000_0000; q1 = 32'd64;
    push_page(1, a1, 64);
    cpl_budget = 100000; s1 = 1'b1;
    wait_freed(1, 400, "t1_free");
    check("t1_beat0_lit", cap_b0.size() > 0 ? cap_b0[0] : 64'hX, 64'h2000_0080_0100_00FF);
    check("t1_beat1_lit", cap_b1.size() > 0 ? cap_b1[0] : 64'hX, 64'h0000_0001_0000_0000);
    idle(20);
    check("t1_cur_moved", n_tlp, 1);
    s1 = 1'b0;
    a2 = 64'h0000_0002_0000_2000; q2 = 32'd8;
    push_page(2, a2, 8);
    s2 = 1'b1;
    wait_freed(2, 200, "t1_free2");
    s2 = 1'b0;

    // 200 qwords: three full chunks plus a short tail.
    do_reset();
    cid = 16'hABCD; a1 = 64'h0000_0003_0000_0000; q1 = 32'd200;
    push_page(1, a1, 200);
    cpl_budget = 100000; s1 = 1'b1;
    wait_freed(1, 1000, "t2_free");
    s1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < cap_b0.size()) begin
        check("t2_len", cap_b0[i][41:32], 10'(exp_len[i]));
        check("t2_tag", cap_b0[i][12:8], 5'(i));
        check("t2_addr", cap_b1[i] - a1, exp_off[i]);
      end else begin
        n_tests++; n_fail++;
        $display("FAIL t2_count: got %0d TLPs required 4", cap_b0.size());
      end
    end

    // Outstanding window stall.
    do_reset();
    a1 = 64'h0000_0004_0000_0000; q1 = 32'd256;
    push_page(1, a1, 256);
    cpl_budget = 0; s1 = 1'b1;
    idle(40);
    check("t3_two_req", n_tlp, 2);
    cpl_budget = 1;
    idle(30);
    check("t3_still_stalled", n_tlp, 2);
    cpl_budget = 63;
    idle(100);
    check("t3_third_req", n_tlp, 3);
    cpl_budget = 100000;
    wait_freed(1, 1000, "t3_free");
    s1 = 1'b0;

    // Core back-pressure on both beats.
    do_reset();
    a1 = 64'h0000_0005_0000_0000; q1 = 32'd128;
    push_page(1, a1, 128);
    cpl_budget = 100000;
    trn_if.trn_tdst_rdy_n = 1'b1; s1 = 1'b1;
    wait_src(50, "t4_sof_seen");
    idle(4);
    trn_if.trn_tdst_rdy_n = 1'b0;
    idle(1);
    trn_if.trn_tdst_rdy_n = 1'b1;
    idle(3);
    trn_if.trn_tdst_rdy_n = 1'b0;
    wait_freed(1, 600, "t4_free");
    s1 = 1'b0;
    check("t4_tlps", n_tlp, 2);

    // Both pages unlocked, then an empty page.
    do_reset();
    a1 = 64'h0000_0006_0000_0000; q1 = 32'd8;
    a2 = 64'h0000_0007_0000_1000; q2 = 32'd8;
    push_page(1, a1, 8);
    push_page(2, a2, 8);
    cpl_budget = 100000; s1 = 1'b1; s2 = 1'b1;
    wait_freed(1, 200, "t5_free1");
    s1 = 1'b0;
    wait_freed(2, 200, "t5_free2");
    s2 = 1'b0;
    check("t5_page2_addr", cap_b1.size() > 1 ? cap_b1[1] : 64'hX, 64'h0000_0007_0000_1000);
    q1 = 32'd0;
    push_page(1, a1, 0);
    s1 = 1'b1;
    wait_freed(3, 50, "t5_free_empty");
    s1 = 1'b0;
    idle(5);
    check("t5_no_tlp_empty", n_tlp, 2);

    // Address carry across bit 32.
    do_reset();
    a1 = 64'h0000_0000_FFFF_F000; q1 = 32'd1024;
    push_page(1, a1, 1024);
    cpl_budget = 100000; s1 = 1'b1;
    wait_freed(1, 4000, "t6_free");
    s1 = 1'b0;
    check("t6_carry_addr", cap_b1.size() > 8 ? cap_b1[8] : 64'hX, 64'h0000_0001_0000_0000);

    // Low address, then asynchronous reset while beat1 is held.
    do_reset();
    a1 = 64'h0000_0000_8000_0000; q1 = 32'd16;
    push_page(1, a1, 16);
    cpl_budget = 0;
    trn_if.trn_tdst_rdy_n = 1'b1; s1 = 1'b1;
    wait_src(50, "t7_sof_seen");
    trn_if.trn_tdst_rdy_n = 1'b0;
    idle(1);
    trn_if.trn_tdst_rdy_n = 1'b1;
`ifdef TX_RD32_EN
    check("t7_b0_fmt", cap_b0.size() > 0 ? cap_b0[0][63:56] : 8'hX, 8'h00);
    check("t7_b1_addr", trn_if.trn_td[63:32], 32'h8000_0000);
    check("t7_b1_trem", trn_if.trn_trem_n, 8'h0F);
`else
    check("t7_b0_fmt", cap_b0.size() > 0 ? cap_b0[0][63:56] : 8'hX, 8'h20);
    check("t7_b1_addr", trn_if.trn_td, 64'h0000_0000_8000_0000);
    check("t7_b1_trem", trn_if.trn_trem_n, 8'h00);
`endif
    #2;
    reset_n = 1'b0;
    #1;
    check("t7_async_rst",
          {trn_if.trn_tsof_n, trn_if.trn_teof_n, trn_if.trn_tsrc_rdy_n,
           trn_if.trn_trem_n, trn_if.trn_td, f1, f2},
          {3'b111, 8'hFF, 64'h0, 2'b00});
    do_reset();
    idle(10);
    check("t7_no_resume", n_tlp, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the end of the sequence");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire
